// File: rtl/shreg_univ_seq.sv
// Universal shift register with a small sequencer for multi-step shift and rotate operations.
// Optional registered parity output is enabled by defining SHREG_UNIV_PARITY_EN.
module shreg_univ_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             pclk,
    input  logic             prst_n,
    input  logic             pen,
    input  logic             pclr,
    input  logic [2:0]       pmode,
    input  logic             pstart,
    input  logic [CNT_W-1:0] pcount,
    input  logic [WIDTH-1:0] pd,
    input  logic             psi,
    output logic [WIDTH-1:0] pq,
    output logic             pso,
    output logic             pbusy,
    output logic             pdone,
`ifdef SHREG_UNIV_PARITY_EN
    output logic             pparity,
`endif
    output logic             o_dbg_state
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [2:0]       r_mode;
    logic [2:0]       w_mode_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_is_shift;

    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] m,
                                                input logic [WIDTH-1:0] q,
                                                input logic si);
        case (m)
            MODE_SHL: f_step = {q[WIDTH-2:0], si};
            MODE_SHR: f_step = {si, q[WIDTH-1:1]};
            MODE_ROL: f_step = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: f_step = {q[0], q[WIDTH-1:1]};
            default:  f_step = q;
        endcase
    endfunction

    assign w_is_shift = (pmode == MODE_SHL) || (pmode == MODE_SHR) ||
                        (pmode == MODE_ROL) || (pmode == MODE_ROR);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear beats the enable; a cleared op never reports done.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        if (pclr) begin
            w_state_nxt = ST_IDLE;
            w_q_nxt     = '0;
            w_rem_nxt   = '0;
            w_mode_nxt  = MODE_HOLD;
        end else if (pen) begin
            case (r_state)
                ST_IDLE: begin
                    if (pmode == MODE_LOAD) begin
                        w_q_nxt = pd;
                    end else if (w_is_shift && pstart) begin
                        w_mode_nxt = pmode;
                        if (pcount == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_q_nxt = f_step(pmode, r_q, psi);
                            if (pcount == CNT_W'(1)) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_rem_nxt   = pcount - CNT_W'(1);
                                w_state_nxt = ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    w_q_nxt = f_step(r_mode, r_q, psi);
                    if (r_rem > CNT_W'(1)) begin
                        w_rem_nxt = r_rem - CNT_W'(1);
                    end else begin
                        w_rem_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_mode <= MODE_HOLD;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_rem  <= w_rem_nxt;
            r_mode <= w_mode_nxt;
            r_done <= w_done_nxt;
        end
    end

`ifdef SHREG_UNIV_PARITY_EN
    logic r_parity;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_q_nxt;
        end
    end

    assign pparity = r_parity;
`endif

    // Right-moving modes shift out of bit 0, everything else out of the MSB.
    assign pso         = ((r_mode == MODE_SHR) || (r_mode == MODE_ROR)) ? r_q[0] : r_q[WIDTH-1];
    assign pq          = r_q;
    assign pbusy       = (r_state == ST_RUN);
    assign pdone       = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shreg_univ_seq.sv
// Directed bench for shreg_univ_seq: per-cycle vector table plus reset and long-rotate sequences.
module tb_shreg_univ_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int NVEC  = 34;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;

    logic             pclk;
    logic             prst_n;
    logic             pen;
    logic             pclr;
    logic [2:0]       pmode;
    logic             pstart;
    logic [CNT_W-1:0] pcount;
    logic [WIDTH-1:0] pd;
    logic             psi;
    logic [WIDTH-1:0] pq;
    logic             pso;
    logic             pbusy;
    logic             pdone;
    logic             o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic             clr;
        logic             en;
        logic [2:0]       mode;
        logic             start;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] d;
        logic             si;
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             so;
    } vec_t;

    vec_t vecs[NVEC];

    shreg_univ_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .pclk        (pclk),
        .prst_n      (prst_n),
        .pen         (pen),
        .pclr        (pclr),
        .pmode       (pmode),
        .pstart      (pstart),
        .pcount      (pcount),
        .pd          (pd),
        .psi         (psi),
        .pq          (pq),
        .pso         (pso),
        .pbusy       (pbusy),
        .pdone       (pdone),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic en, input logic [2:0] mode,
                                input logic start, input logic [CNT_W-1:0] cnt,
                                input logic [WIDTH-1:0] d, input logic si,
                                input logic [WIDTH-1:0] q, input logic busy,
                                input logic done, input logic so);
        vec_t v;
        v.clr = clr; v.en = en; v.mode = mode; v.start = start; v.cnt = cnt;
        v.d = d; v.si = si; v.q = q; v.busy = busy; v.done = done; v.so = so;
        return v;
    endfunction

    task automatic drive(input logic clr, input logic en, input logic [2:0] mode,
                         input logic start, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] d, input logic si);
        pclr = clr; pen = en; pmode = mode; pstart = start; pcount = cnt; pd = d; psi = si;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        drive(v.clr, v.en, v.mode, v.start, v.cnt, v.d, v.si);
        @(posedge pclk);
        #1;
        chk($sformatf("v%0d_q", idx), 32'(pq), 32'(v.q));
        chk($sformatf("v%0d_busy", idx), 32'(pbusy), 32'(v.busy));
        chk($sformatf("v%0d_done", idx), 32'(pdone), 32'(v.done));
        chk($sformatf("v%0d_so", idx), 32'(pso), 32'(v.so));
        chk($sformatf("v%0d_state", idx), 32'(o_dbg_state), 32'(v.busy));
    endtask

    initial begin
        int   edges;
        logic seen;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] e;

        //             clr en mode    st cnt d         si   q          busy done so
        vecs[0]  = mk(0, 1, M_LOAD, 0, 0,  16'hA5C3, 0,   16'hA5C3,  0, 0, 1);
        vecs[1]  = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'hA5C3,  0, 0, 1);
        vecs[2]  = mk(0, 1, 3'b110, 1, 3,  16'h0000, 0,   16'hA5C3,  0, 0, 1);
        vecs[3]  = mk(0, 1, M_SHL,  0, 3,  16'h0000, 1,   16'hA5C3,  0, 0, 1);
        vecs[4]  = mk(0, 1, M_LOAD, 0, 0,  16'h8001, 0,   16'h8001,  0, 0, 1);
        vecs[5]  = mk(0, 1, M_ROL,  1, 3,  16'h0000, 0,   16'h0003,  1, 0, 0);
        vecs[6]  = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0006,  1, 0, 0);
        vecs[7]  = mk(0, 1, M_LOAD, 1, 9,  16'hFFFF, 0,   16'h000C,  0, 1, 0);
        vecs[8]  = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h000C,  0, 0, 0);
        vecs[9]  = mk(1, 0, M_LOAD, 0, 0,  16'hFFFF, 0,   16'h0000,  0, 0, 0);
        vecs[10] = mk(0, 1, M_SHR,  1, 4,  16'h0000, 1,   16'h8000,  1, 0, 0);
        vecs[11] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 1,   16'hC000,  1, 0, 0);
        vecs[12] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 1,   16'hE000,  1, 0, 0);
        vecs[13] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 1,   16'hF000,  0, 1, 0);
        vecs[14] = mk(0, 1, M_LOAD, 0, 0,  16'h0001, 0,   16'h0001,  0, 0, 1);
        vecs[15] = mk(0, 0, M_LOAD, 0, 0,  16'hFFFF, 0,   16'h0001,  0, 0, 1);
        vecs[16] = mk(0, 1, M_SHL,  1, 5,  16'h0000, 0,   16'h0002,  1, 0, 0);
        vecs[17] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0004,  1, 0, 0);
        vecs[18] = mk(0, 0, M_HOLD, 0, 0,  16'h0000, 1,   16'h0004,  1, 0, 0);
        vecs[19] = mk(0, 0, M_LOAD, 1, 2,  16'hFFFF, 1,   16'h0004,  1, 0, 0);
        vecs[20] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0008,  1, 0, 0);
        vecs[21] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0010,  1, 0, 0);
        vecs[22] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0020,  0, 1, 0);
        vecs[23] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0020,  0, 0, 0);
        vecs[24] = mk(0, 1, M_ROR,  1, 0,  16'h0000, 0,   16'h0020,  0, 1, 0);
        vecs[25] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0020,  0, 0, 0);
        vecs[26] = mk(0, 1, M_ROR,  1, 1,  16'h0000, 0,   16'h0010,  0, 1, 0);
        vecs[27] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0010,  0, 0, 0);
        vecs[28] = mk(0, 1, M_LOAD, 0, 0,  16'h8001, 0,   16'h8001,  0, 0, 1);
        vecs[29] = mk(0, 1, M_ROL,  1, 5,  16'h0000, 0,   16'h0003,  1, 0, 0);
        vecs[30] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0006,  1, 0, 0);
        vecs[31] = mk(1, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0000,  0, 0, 0);
        vecs[32] = mk(0, 1, M_HOLD, 0, 0,  16'h0000, 0,   16'h0000,  0, 0, 0);
        vecs[33] = mk(0, 1, M_SHL,  0, 0,  16'h0000, 1,   16'h0000,  0, 0, 0);

        prst_n = 1'b0;
        drive(0, 0, M_HOLD, 0, 0, 16'h0000, 0);
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_q", 32'(pq), 32'h0);
        chk("rst_busy", 32'(pbusy), 32'h0);
        chk("rst_done", 32'(pdone), 32'h0);
        chk("rst_so", 32'(pso), 32'h0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk);
        #1;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // asynchronous reset in the middle of a running rotate
        drive(0, 1, M_LOAD, 0, 0, 16'h8001, 0);
        @(posedge pclk); #1;
        drive(0, 1, M_ROL, 1, 10, 16'h0000, 0);
        @(posedge pclk); #1;
        chk("arst_pre_busy", 32'(pbusy), 32'h1);
        chk("arst_pre_q", 32'(pq), 32'h0003);
        drive(0, 1, M_HOLD, 0, 0, 16'h0000, 0);
        @(posedge pclk); #3;
        prst_n = 1'b0;
        #1;
        chk("arst_q", 32'(pq), 32'h0);
        chk("arst_busy", 32'(pbusy), 32'h0);
        chk("arst_done", 32'(pdone), 32'h0);
        chk("arst_state", 32'(o_dbg_state), 32'h0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk); #1;
        chk("arst_post_q", 32'(pq), 32'h0);
        chk("arst_post_busy", 32'(pbusy), 32'h0);

        // 31-step rotate on a 16-bit register, stepped against a rotation model
        drive(0, 1, M_LOAD, 0, 0, 16'h1234, 0);
        @(posedge pclk); #1;
        m = 16'h1234;
        for (int i = 0; i < 31; i++) begin
            m = {m[WIDTH-2:0], m[WIDTH-1]};
            exp_q.push_back(m);
        end
        drive(0, 1, M_ROL, 1, 31, 16'h0000, 0);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge pclk); #1;
            drive(0, 1, M_HOLD, 0, 0, 16'h0000, 0);
            edges++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rol31_q_e%0d", edges), 32'(pq), 32'(e));
                chk($sformatf("rol31_busy_e%0d", edges), 32'(pbusy), 32'(edges < 31));
            end
            if (pdone) seen = 1'b1;
        end
        chk("rol31_done_seen", 32'(seen), 32'h1);
        chk("rol31_edges", 32'(edges), 32'd31);
        chk("rol31_final_q", 32'(pq), 32'h091A);
        @(posedge pclk); #1;
        chk("rol31_done_clear", 32'(pdone), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
